// File: rtl/apb_pkg.sv
// Shared APB types for masters that drive the memory slave port.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

package apb_pkg;

    localparam int unsigned APB_ADDR_WIDTH      = `APB_ADDR_WIDTH;
    localparam int unsigned APB_DATA_WIDTH      = `APB_DATA_WIDTH;
    localparam int unsigned APB_STRB_WIDTH      = APB_DATA_WIDTH / 8;
    localparam int unsigned APB_TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_fsm_enum;

    typedef logic [APB_ADDR_WIDTH-1:0] addr_t;
    typedef logic [APB_DATA_WIDTH-1:0] data_t;
    typedef logic [APB_STRB_WIDTH-1:0] strb_t;

    typedef struct packed {
        logic  write;
        addr_t addr;
        data_t wdata;
        strb_t strb;
    } apb_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last grant; pointer moves only on advance.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       advance,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] ptr
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    logic [PW-1:0] ptr_q, ptr_d, win;
    logic [PW:0]   sum;

    always_comb begin
        grant = '0;
        win   = '0;
        sum   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(i);
            if (sum >= (PW+1)'(NUM_REQ)) begin
                sum = sum - (PW+1)'(NUM_REQ);
            end
            if (req[sum[PW-1:0]] && (grant == '0)) begin
                grant[sum[PW-1:0]] = 1'b1;
                win                = sum[PW-1:0];
            end
        end
    end

    assign ptr_d = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance && (req != '0)) begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin arbitrated APB master sharing one slave port between NUM_REQ requesters,
// with a PREADY watchdog that aborts hung transfers.
module apb_rr_master
    import apb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = APB_TIMEOUT_DEFAULT,
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                             PCLK,
    input  logic                             PRESETn,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    input  logic [NUM_REQ*STRB_WIDTH-1:0]    req_strb,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [STRB_WIDTH-1:0]            PSTRB,
    input  logic [DATA_WIDTH-1:0]            PRDATA,
    input  logic                             PREADY,
    input  logic                             PSLVERR
);

    apb_fsm_enum               state_q, state_d;
    apb_cmd_t                  cmd_q, cmd_d;
    logic [NUM_REQ-1:0]        owner_q, owner_d;
    logic [7:0]                wdog_q, wdog_d;
    logic [NUM_REQ-1:0]        rsp_valid_q;
    logic [DATA_WIDTH-1:0]     rsp_rdata_q;
    logic                      rsp_err_q;

    logic [NUM_REQ-1:0]        grant;
    logic [$clog2(NUM_REQ)-1:0] arb_ptr;
    logic                      any_req, timed_out, done, can_grant, advance;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .clk    (PCLK),
        .rst_n  (PRESETn),
        .req    (req_valid),
        .advance(advance),
        .grant  (grant),
        .ptr    (arb_ptr)
    );

    // Pointer is exported by the arbiter for masters that report it; not needed here.
    logic unused_ptr;
    assign unused_ptr = ^arb_ptr;

    assign any_req   = |req_valid;
    assign timed_out = (wdog_q == 8'(TIMEOUT)) && !PREADY;
    assign done      = (state_q == ACCESS) && (PREADY || timed_out);
    assign can_grant = (state_q == IDLE) || done;
    assign advance   = can_grant && any_req;
    assign req_ready = advance ? grant : '0;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        owner_d = owner_q;
        wdog_d  = wdog_q;

        unique case (state_q)
            IDLE: begin
                if (any_req) state_d = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
                wdog_d  = '0;
            end
            ACCESS: begin
                if (done) begin
                    state_d = any_req ? SETUP : IDLE;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            owner_d = grant;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    cmd_d.write = req_write[i];
                    cmd_d.addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    cmd_d.wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                    cmd_d.strb  = req_strb[i*STRB_WIDTH +: STRB_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            owner_q     <= '0;
            wdog_q      <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            owner_q     <= owner_d;
            wdog_q      <= wdog_d;
            rsp_valid_q <= done ? owner_q : '0;
            // Aborts and writes return zero data; a timeout always reports an error.
            rsp_rdata_q <= (done && PREADY && !cmd_q.write) ? PRDATA : '0;
            rsp_err_q   <= done && (!PREADY || PSLVERR);
        end
    end

    assign PSEL      = (state_q != IDLE);
    assign PENABLE   = (state_q == ACCESS);
    assign PWRITE    = cmd_q.write;
    assign PADDR     = cmd_q.addr;
    assign PWDATA    = cmd_q.wdata;
    assign PSTRB     = cmd_q.strb;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: transaction-level model checked every cycle, directed scenarios
// pinned with literal expectations, then randomized requesters and slave.
module tb_apb_rr_master;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 15;

    logic            PCLK = 1'b0;
    logic            PRESETn;
    logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*SW-1:0] req_strb;
    logic [DW-1:0]   rsp_rdata, PWDATA, PRDATA;
    logic            rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [AW-1:0]   PADDR;
    logic [SW-1:0]   PSTRB;

    apb_rr_master #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Observation logs filled by the compare process.
    int           cyc = 0;
    int           setup_cnt = 0, access_cnt = 0;
    logic [SW-1:0] last_pstrb;
    logic [N-1:0] rsp_vec[$];
    logic [DW-1:0] rsp_dat[$];
    logic         rsp_er[$];
    int           rsp_cyc[$];
    int           grant_log[$];
    int           grant_cyc[$];
    int           acc_cnt[N];

    // Transaction-level model state.
    bit           m_on = 0, m_busy = 0, m_acc = 0;
    int           m_owner, m_last, m_waits;
    logic         m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_strb;
    bit           e_rsp = 0;
    int           e_idx;
    logic [DW-1:0] e_rdata;
    logic         e_err;

    initial for (int i = 0; i < N; i++) acc_cnt[i] = 0;

    always @(negedge PCLK) begin : compare
        int   win;
        logic fin;
        cyc++;
        if (!PRESETn) begin
            m_on = 1; m_busy = 0; m_acc = 0; m_last = N - 1; e_rsp = 0;
        end else if (m_on) begin
            chk("rsp_valid", rsp_valid, e_rsp ? (64'd1 << e_idx) : 64'd0);
            chk("rsp_rdata", rsp_rdata, e_rsp ? e_rdata : 0);
            chk("rsp_err", rsp_err, e_rsp ? e_err : 0);
            if (rsp_valid != 0) begin
                rsp_vec.push_back(rsp_valid); rsp_dat.push_back(rsp_rdata);
                rsp_er.push_back(rsp_err);    rsp_cyc.push_back(cyc);
            end
            chk("psel", PSEL, m_busy);
            chk("penable", PENABLE, m_busy && m_acc);
            if (m_busy) begin
                chk("pwrite", PWRITE, m_write);
                chk("paddr", PADDR, m_addr);
                chk("pwdata", PWDATA, m_wdata);
                chk("pstrb", PSTRB, m_strb);
            end
            if (PSEL && !PENABLE) setup_cnt++;
            if (PSEL && PENABLE) begin access_cnt++; last_pstrb = PSTRB; end

            fin = m_busy && m_acc && (PREADY || (m_waits == TO));
            win = -1;
            if (!m_busy || fin) begin
                for (int k = 1; k <= N; k++) begin
                    if (win < 0 && req_valid[(m_last + k) % N]) win = (m_last + k) % N;
                end
            end
            chk("req_ready", req_ready, (win >= 0) ? (64'd1 << win) : 64'd0);

            e_rsp = fin;
            if (fin) begin
                e_idx   = m_owner;
                e_rdata = (PREADY && !m_write) ? PRDATA : '0;
                e_err   = PREADY ? PSLVERR : 1'b1;
            end
            if (win >= 0) begin
                grant_log.push_back(win); grant_cyc.push_back(cyc);
                acc_cnt[win]++;
                m_busy = 1; m_acc = 0; m_owner = win; m_last = win;
                m_write = req_write[win];
                m_addr  = req_addr[win*AW +: AW];
                m_wdata = req_wdata[win*DW +: DW];
                m_strb  = req_strb[win*SW +: SW];
            end else if (fin) begin
                m_busy = 0;
            end else if (m_busy && !m_acc) begin
                m_acc = 1; m_waits = 0;
            end else if (m_busy) begin
                m_waits++;
            end
        end
    end

    // Stimulus side: requester agents and slave.
    int  acc_used[N];
    bit  sticky[N];
    bit  rand_mode = 0;
    int  s_waits = 0, s_cnt = 0;

    task automatic new_cmd(input int i);
        req_valid[i] = 1'b1;
        req_write[i] = 1'($urandom);
        req_addr[i*AW +: AW]  = $urandom;
        req_wdata[i*DW +: DW] = $urandom;
        req_strb[i*SW +: SW]  = 4'($urandom);
    endtask

    task automatic issue(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
        req_valid[i] = 1'b1;
        req_write[i] = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_strb[i*SW +: SW]  = s;
    endtask

    task automatic tick();
        int r;
        @(posedge PCLK);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_cnt[i] != acc_used[i]) begin
                acc_used[i] = acc_cnt[i];
                if (sticky[i]) begin
                    new_cmd(i);
                end else begin
                    // Scramble the payload so only the latched copy can reach the bus.
                    new_cmd(i);
                    req_valid[i] = 1'b0;
                end
            end
            if (rand_mode && !req_valid[i] && ($urandom_range(0, 3) == 0)) new_cmd(i);
        end
        if (PSEL && !PENABLE) begin
            s_cnt = 0;
            if (rand_mode) begin
                r = int'($urandom_range(0, 19));
                s_waits = (r == 0) ? 40 : r % 4;
            end
        end
        if (PSEL && PENABLE) begin
            PREADY = (s_cnt >= s_waits);
            s_cnt++;
        end else begin
            PREADY = 1'($urandom);
        end
        if (rand_mode) begin
            PSLVERR = 1'($urandom);
            PRDATA  = $urandom;
        end
    endtask

    task automatic do_reset();
        PRESETn = 1'b0;
        tick();
        tick();
        PRESETn = 1'b1;
    endtask

    task automatic wait_rsp(input int target, input int limit, input string name);
        int k = 0;
        while (rsp_vec.size() < target && k < limit) begin
            tick();
            k++;
        end
        chk({name, " completed"}, rsp_vec.size() >= target, 1);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((req_valid != 0 || PSEL) && k < 300) begin
            tick();
            k++;
        end
        repeat (2) tick();
        chk({name, " drained"}, (req_valid == 0) && !PSEL, 1);
    endtask

    initial begin : main
        int nr, ng, bs, ba, k, inter;
        bit found;
        PRESETn = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        for (int i = 0; i < N; i++) begin acc_used[i] = 0; sticky[i] = 0; end
        do_reset();
        tick();
        chk("reset psel", PSEL, 0);
        chk("reset rsp_valid", rsp_valid, 0);

        // Single read, one wait state.
        s_waits = 1; PRDATA = 32'hDEADBEEF; PSLVERR = 1'b0;
        nr = rsp_vec.size(); bs = setup_cnt; ba = access_cnt;
        issue(2, 1'b0, 32'h20, 32'h0, 4'h0);
        wait_rsp(nr + 1, 20, "t1");
        chk("t1 rsp_valid", rsp_vec[nr], 4'b0100);
        chk("t1 rsp_rdata", rsp_dat[nr], 32'hDEADBEEF);
        chk("t1 rsp_err", rsp_er[nr], 0);
        chk("t1 setup cycles", setup_cnt - bs, 1);
        chk("t1 access cycles", access_cnt - ba, 2);
        chk("t1 latency", rsp_cyc[nr] - grant_cyc[grant_cyc.size()-1], 4);

        // All four requesters from reset, zero-wait writes back to back.
        do_reset();
        s_waits = 0;
        nr = rsp_vec.size(); ng = grant_log.size();
        for (int i = 0; i < N; i++) issue(i, 1'b1, 32'h40 + i, $urandom, 4'hF);
        wait_rsp(nr + 4, 40, "t2");
        for (int i = 0; i < N; i++) begin
            chk("t2 grant order", grant_log[ng+i], i);
            chk("t2 rsp order", rsp_vec[nr+i], 1 << i);
        end
        chk("t2 back-to-back span", rsp_cyc[nr+3] - grant_cyc[ng], 9);

        // Write with slave error and partial strobes.
        PSLVERR = 1'b1; nr = rsp_vec.size();
        issue(0, 1'b1, 32'h05, 32'h12345678, 4'b0011);
        wait_rsp(nr + 1, 20, "t3");
        chk("t3 pstrb", last_pstrb, 4'h3);
        chk("t3 rsp_err", rsp_er[nr], 1);
        chk("t3 rsp_rdata", rsp_dat[nr], 0);
        PSLVERR = 1'b0;

        // Hung slave: watchdog abort, then a normal read.
        s_waits = 1000; PRDATA = 32'hCAFEF00D;
        nr = rsp_vec.size(); ba = access_cnt;
        issue(1, 1'b0, 32'h10, 32'h0, 4'hF);
        wait_rsp(nr + 1, 40, "t4");
        chk("t4 rsp_err", rsp_er[nr], 1);
        chk("t4 rsp_rdata", rsp_dat[nr], 0);
        chk("t4 access cycles", access_cnt - ba, TO + 1);
        chk("t4 latency", rsp_cyc[nr] - grant_cyc[grant_cyc.size()-1], TO + 3);
        chk("t4 back to idle", PSEL, 0);
        s_waits = 0; nr = rsp_vec.size();
        issue(1, 1'b0, 32'h14, 32'h0, 4'hF);
        wait_rsp(nr + 1, 20, "t4b");
        chk("t4b rsp_err", rsp_er[nr], 0);
        chk("t4b rsp_rdata", rsp_dat[nr], 32'hCAFEF00D);

        // Fairness: requester 0 always valid, requester 3 joins later.
        do_reset();
        s_waits = 1; sticky[0] = 1;
        new_cmd(0);
        repeat (5) tick();
        ng = grant_log.size();
        new_cmd(3);
        found = 0; k = 0; inter = 0;
        while (!found && k < 50) begin
            tick();
            k++;
            for (int j = ng; j < grant_log.size(); j++) if (grant_log[j] == 3) found = 1;
        end
        for (int j = ng; j < grant_log.size() && grant_log[j] != 3; j++) inter++;
        chk("t5 req3 granted", found, 1);
        chk("t5 grants before req3 within 1", inter <= 1, 1);
        sticky[0] = 0;
        drain("t5");

        // Reset during the ACCESS phase of a write by requester 0.
        s_waits = 5;
        issue(0, 1'b1, 32'h80, 32'hA5A5A5A5, 4'hF);
        k = 0;
        while (!(PSEL && PENABLE) && k < 20) begin tick(); k++; end
        chk("t6 reached access", PSEL && PENABLE, 1);
        nr = rsp_vec.size();
        PRESETn = 1'b0;
        tick();
        chk("t6 psel after reset", PSEL, 0);
        chk("t6 penable after reset", PENABLE, 0);
        PRESETn = 1'b1; s_waits = 0;
        ng = grant_log.size();
        issue(0, 1'b0, 32'h84, 32'h0, 4'hF);
        issue(1, 1'b0, 32'h88, 32'h0, 4'hF);
        wait_rsp(nr + 2, 30, "t6");
        chk("t6 first grant", grant_log[ng], 0);
        chk("t6 first rsp", rsp_vec[nr], 4'b0001);
        chk("t6 second rsp", rsp_vec[nr+1], 4'b0010);

        // Randomized traffic with occasional resets.
        rand_mode = 1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                PRESETn = 1'b0;
                tick();
                PRESETn = 1'b1;
            end
            tick();
        end
        rand_mode = 0; s_waits = 0;
        drain("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
Round-robin arbitrated APB master that shares one APB3/APB4 slave port (the team's dual-port memory) between NUM_REQ on-chip requesters. Each requester issues single read/write commands over a valid/ready interface. The block arbitrates between them, sequences the APB SETUP/ACCESS phases, waits on PREADY, and returns read data and error status to the winning requester. A watchdog aborts transfers whose slave never asserts PREADY.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, `APB_ADDR_WIDTH, PADDR width
DATA_WIDTH, `APB_DATA_WIDTH, PWDATA/PRDATA width; STRB_WIDTH = DATA_WIDTH/8
TIMEOUT, 15, max ACCESS cycles with PREADY=0 before abort (1..255)

Ports:
PCLK  in  1  single clock; all logic on rising edge
PRESETn  in  1  synchronous, active-low reset
req_valid  in  NUM_REQ  per-requester command valid; held until req_ready
req_write  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH+:ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
req_strb  in  NUM_REQ*STRB_WIDTH  packed byte strobes
req_ready  out  NUM_REQ  one-hot, combinational; command accepted this cycle
rsp_valid  out  NUM_REQ  one-hot, registered, one-cycle completion pulse
rsp_rdata  out  DATA_WIDTH  read data (0 for writes and aborts), valid with rsp_valid
rsp_err  out  1  PSLVERR or timeout, valid with rsp_valid
PSEL, PENABLE, PWRITE  out  1 each  APB master controls
PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH; PSTRB  out  STRB_WIDTH
PRDATA  in  DATA_WIDTH; PREADY  in  1; PSLVERR  in  1

Behaviour:
- Reset (PRESETn=0 at a PCLK edge): state=IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB = 0; rsp_valid=0, rsp_rdata=0, rsp_err=0; RR pointer=0 (requester 0 highest priority); watchdog counter=0. Reset mid-transfer abandons the transfer. No rsp_valid is issued for it.
- FSM uses apb_fsm_enum IDLE/SETUP/ACCESS:
  - IDLE: if any req_valid, grant the winner (req_ready[g]=1), latch its write/addr/wdata/strb, and go to SETUP.
  - SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then go to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1, and PADDR/PWRITE/PWDATA/PSTRB stay stable. The transfer completes on the first edge with PREADY=1.
    - On completion, if any req_valid is high in that cycle, grant the next winner in the same cycle and go straight to SETUP (back-to-back, PSEL stays high). Otherwise go to IDLE and drop PSEL/PENABLE.
- Arbitration: round robin. Search starts at index (last_grant+1) mod NUM_REQ. The pointer updates only on a grant. req_ready is asserted only in IDLE or on the ACCESS completion cycle, never elsewhere.
- Response: on the edge after completion, rsp_valid[g]=1 for one cycle.
  - rsp_rdata = PRDATA sampled at completion for reads, 0 for writes.
  - rsp_err = PSLVERR sampled at completion.
  - Outside the pulse, rsp_rdata and rsp_err are driven 0.
- Latency: an uncontended read against a zero-wait slave gives req_ready at cycle 0, SETUP at cycle 1, ACCESS/complete at cycle 2, and rsp_valid at cycle 3.
- Watchdog: an 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the counter equals TIMEOUT and PREADY=0, the transfer aborts: next state follows the completion rules, rsp_err=1, rsp_rdata=0.
  - If PREADY=1 arrives in that same cycle, it is a normal completion (PREADY wins).
- Simultaneous events: a new req_valid during SETUP/ACCESS waits. A requester whose rsp_valid is high may reassert req_valid in that same cycle. PSLVERR is ignored unless PREADY=1.
- Latched command: requesters may change their payload after the req_ready cycle without affecting the bus.

Decomposition:
- apb_pkg: reuse apb_fsm_enum, addr_t, data_t, and add strb_t = logic [STRB_WIDTH-1:0].
- Add to apb_pkg: localparam APB_TIMEOUT_DEFAULT=15 and typedef struct apb_cmd_t {write, addr, wdata, strb} for the latched command.
- Sub-module rr_arbiter (NUM_REQ): inputs req vector and advance; outputs one-hot grant and the pointer. Reused by future APB masters.

Test Plan:
- Single read, req 2, addr 0x20, slave 1 wait state, PRDATA=0xDEADBEEF -> SETUP 1 cycle, ACCESS 2 cycles, rsp_valid=4'b0100, rsp_rdata=0xDEADBEEF, rsp_err=0.
- All 4 requesters hold valid from reset, writes to 0x40..0x43 -> grants in order 0,1,2,3, PSEL continuously high, no IDLE between transfers, 4 rsp pulses in the same order.
- Write to 0x05 with PSLVERR=1 at completion, strb 4'b0011 -> PSTRB=0x3 on the bus, rsp_err=1, rsp_rdata=0.
- Slave holds PREADY=0 forever, TIMEOUT=15 -> abort after 15 ACCESS cycles, rsp_err=1, FSM returns to IDLE, next request proceeds normally.
- Fairness: req 0 always valid, req 3 valid from cycle 5 -> req 3 granted no later than the second completion after its assertion.
- PRESETn=0 during ACCESS of a write -> next cycle PSEL=PENABLE=0, no rsp_valid, pointer=0; after release, req 0 wins over a simultaneous req 1.
